// File: rtl/aq_axis_rgb_pack.sv
// aq_axis_rgb_pack: packs 24-bit RGB pixels into dense 32-bit little-endian words and checks frame length
module aq_axis_rgb_pack (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic        S_AXIS_TLAST,
  output logic [31:0] M_AXIS_TDATA,
  output logic [3:0]  M_AXIS_TSTRB,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TLAST,
  input  logic [15:0] WIDTH,
  input  logic [15:0] HEIGHT,
  input  logic        CLEAR,
  output logic [31:0] PIXEL_COUNT,
  output logic        FRAME_DONE,
  output logic        ERR_SHORT,
  output logic        ERR_LONG
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [1:0] phase, phase_n;
  logic [23:0] carry, carry_n, px;
  logic [31:0] count, total, expected, ld_data;
  logic [3:0] ld_strb;
  logic acc, last, load, ld_last, set_short, set_long, unused_hi;
  assign px = S_AXIS_TDATA[23:0];
  assign unused_hi = ^S_AXIS_TDATA[31:24];
  assign S_AXIS_TREADY = ARESETN & (state == RUN) & (~M_AXIS_TVALID | M_AXIS_TREADY);
  assign acc = S_AXIS_TVALID & S_AXIS_TREADY;
  assign last = acc & S_AXIS_TLAST;
  assign total = &count ? count : count + 32'd1;
  assign expected = {16'd0, WIDTH} * {16'd0, HEIGHT};
  assign set_short = last & (total < expected);
  assign set_long = last & (total > expected);
  always_comb begin
    state_n = state;
    phase_n = phase;
    carry_n = carry;
    load = 1'b0;
    ld_data = 32'd0;
    ld_strb = 4'b1111;
    ld_last = 1'b0;
    if (state == FLUSH) begin
      // phase here is one past the TLAST pixel's phase, so it tells how many bytes remain
      if (M_AXIS_TVALID & M_AXIS_TREADY) begin
        load = 1'b1;
        ld_data = {8'd0, carry};
        ld_strb = phase == 2'd2 ? 4'b0011 : 4'b0001;
        ld_last = 1'b1;
        state_n = RUN;
        phase_n = 2'd0;
        carry_n = 24'd0;
      end
    end else if (acc) begin
      phase_n = phase + 2'd1;
      case (phase)
        2'd0: begin
          carry_n = px;
          load = S_AXIS_TLAST;
          ld_data = {8'd0, px};
          ld_strb = 4'b0111;
          ld_last = S_AXIS_TLAST;
        end
        2'd1: begin
          load = 1'b1;
          ld_data = {px[7:0], carry};
          carry_n = {8'd0, px[23:8]};
        end
        2'd2: begin
          load = 1'b1;
          ld_data = {px[15:0], carry[15:0]};
          carry_n = {16'd0, px[23:16]};
        end
        default: begin
          load = 1'b1;
          ld_data = {px, carry[7:0]};
          carry_n = 24'd0;
          ld_last = S_AXIS_TLAST;
        end
      endcase
      if (S_AXIS_TLAST && (phase == 2'd1 || phase == 2'd2)) state_n = FLUSH;
      else if (S_AXIS_TLAST) begin
        phase_n = 2'd0;
        carry_n = 24'd0;
      end
    end
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) state <= RUN;
    else state <= state_n;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      phase <= 2'd0;
      carry <= 24'd0;
      count <= 32'd0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA <= 32'd0;
      M_AXIS_TSTRB <= 4'd0;
      M_AXIS_TLAST <= 1'b0;
      PIXEL_COUNT <= 32'd0;
      FRAME_DONE <= 1'b0;
      ERR_SHORT <= 1'b0;
      ERR_LONG <= 1'b0;
    end else begin
      phase <= phase_n;
      carry <= carry_n;
      if (load) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA <= ld_data;
        M_AXIS_TSTRB <= ld_strb;
        M_AXIS_TLAST <= ld_last;
      end else if (M_AXIS_TREADY) M_AXIS_TVALID <= 1'b0;
      FRAME_DONE <= M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;
      if (last) begin
        count <= 32'd0;
        PIXEL_COUNT <= total;
      end else if (acc && !(&count)) count <= count + 32'd1;
      ERR_SHORT <= set_short | (ERR_SHORT & ~CLEAR);
      ERR_LONG <= set_long | (ERR_LONG & ~CLEAR);
    end
  end
endmodule
